// File: rtl/pkt_proc_sched.sv
// pkt_proc_sched: hands the packet buffer SRAM between network datapath and CPU, releasing each packet via data_processed
`timescale 1ns/1ps
module pkt_proc_sched #(
  parameter int ADDR_W        = 8,
  parameter int MAX_PKT_WORDS = 200,
  parameter int TIMEOUT_CYC   = 4096,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sched_en,
  input  logic              bypass,
  input  logic              full,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              cpu_done,
  output logic              cpu_start,
  output logic              cpu_rst,
  output logic              cpu_mem_sel,
  output logic [ADDR_W-1:0] cpu_base_addr,
  output logic [ADDR_W:0]   cpu_pkt_len,
  output logic              data_processed,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  bypass_cnt,
  output logic [CNT_W-1:0]  timeout_cnt,
  output logic              err
);
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  typedef enum logic [2:0] {IDLE, DECIDE, LOAD, RUN, RELEASE, DRAIN} state_t;
  state_t state;
  logic [TW-1:0] timer;
  logic byp_flag, to_flag, drop;
  logic [ADDR_W-1:0] diff;
  logic [ADDR_W:0] len;
  assign diff = last_addr - first_addr;
  assign len = {1'b0, diff} + (ADDR_W+1)'(1);
  assign busy = state != IDLE;
  assign drop = !full && (state == DECIDE || state == LOAD || state == RUN);
  always_ff @(posedge clk)
    if (rst) begin
      state          <= IDLE;
      timer          <= '0;
      byp_flag       <= 1'b0;
      to_flag        <= 1'b0;
      cpu_start      <= 1'b0;
      cpu_rst        <= 1'b1;
      cpu_mem_sel    <= 1'b0;
      cpu_base_addr  <= '0;
      cpu_pkt_len    <= '0;
      data_processed <= 1'b0;
      pkt_cnt        <= '0;
      bypass_cnt     <= '0;
      timeout_cnt    <= '0;
      err            <= 1'b0;
    end else begin
      cpu_start      <= 1'b0;
      data_processed <= 1'b0;
      if (drop) begin
        err         <= 1'b1;
        cpu_mem_sel <= 1'b0;
        cpu_rst     <= 1'b1;
        state       <= IDLE;
      end else
        case (state)
          IDLE:
            if (full && sched_en) begin
              cpu_base_addr <= first_addr;
              cpu_pkt_len   <= len;
              byp_flag      <= 1'b0;
              to_flag       <= 1'b0;
              state         <= DECIDE;
            end
          DECIDE:
            if (bypass || int'(cpu_pkt_len) > MAX_PKT_WORDS) begin
              byp_flag       <= 1'b1;
              data_processed <= 1'b1;
              state          <= RELEASE;
            end else begin
              cpu_mem_sel <= 1'b1;
              cpu_rst     <= 1'b0;
              timer       <= '0;
              state       <= LOAD;
            end
          LOAD: begin
            cpu_start <= 1'b1;
            state     <= RUN;
          end
          RUN:
            if (cpu_done || timer == TW'(TIMEOUT_CYC - 1)) begin
              to_flag        <= !cpu_done;
              data_processed <= 1'b1;
              cpu_mem_sel    <= 1'b0;
              cpu_rst        <= 1'b1;
              state          <= RELEASE;
            end else
              timer <= timer + TW'(1);
          RELEASE: begin
            pkt_cnt     <= pkt_cnt + CNT_W'(pkt_cnt != '1);
            bypass_cnt  <= bypass_cnt + CNT_W'(byp_flag && bypass_cnt != '1);
            timeout_cnt <= timeout_cnt + CNT_W'(to_flag && timeout_cnt != '1);
            state       <= DRAIN;
          end
          DRAIN: state <= full ? DRAIN : IDLE;
          default: state <= IDLE;
        endcase
    end
endmodule

// File: doc/pkt_proc_sched.md
Name: pkt_proc_sched

Overview:
Sequencer that hands the packet buffer (convertible FIFO/SRAM) back and forth between the network datapath and the five-stage pipeline CPU.
- Detects that a whole packet has been captured (full).
- Grants the SRAM port to the CPU and starts it.
- Waits for completion or timeout, then pulses data_processed so the buffer drains the packet to the output.
- Sits between the buffer block and the CPU core. It drives the buffer's data_processed input with connect=1.

Parameters:
ADDR_W, 8, SRAM address width (matches first_addr/last_addr)
MAX_PKT_WORDS, 200, packets longer than this bypass the CPU
TIMEOUT_CYC, 4096, cycles allowed in RUN before forced release
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sched_en  in  1  1 = accept new packets; 0 = stay in IDLE (an in-flight packet completes normally)
bypass  in  1  1 = never run CPU; release every packet immediately
full  in  1  buffer holds a complete packet
first_addr  in  ADDR_W  SRAM address of first packet word
last_addr  in  ADDR_W  SRAM address of last packet word
cpu_done  in  1  CPU finished processing (level or pulse)
cpu_start  out  1  one-cycle start pulse to CPU
cpu_rst  out  1  holds CPU in reset when 1
cpu_mem_sel  out  1  1 = CPU owns SRAM port (drives buffer Mem_MemWrite/addra mux)
cpu_base_addr  out  ADDR_W  latched first_addr, valid while cpu_mem_sel=1
cpu_pkt_len  out  ADDR_W+1  latched packet length in words
data_processed  out  1  one-cycle release pulse to buffer
busy  out  1  state != IDLE
pkt_cnt  out  CNT_W  packets released
bypass_cnt  out  CNT_W  packets released without CPU
timeout_cnt  out  CNT_W  packets released by timeout
err  out  1  sticky: full dropped outside DRAIN

Behaviour:
- All state registered on posedge clk.
- Reset values: state=IDLE; cpu_start=0, cpu_rst=1, cpu_mem_sel=0, cpu_base_addr=0, cpu_pkt_len=0, data_processed=0, busy=0, all counters=0, err=0, timer=0.
- Reset mid-operation returns to IDLE in the same edge and drops cpu_mem_sel.
- Length rule: len = ((last_addr - first_addr) mod 2^ADDR_W) + 1, computed ADDR_W+1 bits wide. Wrap-around example: first=0xF0, last=0x0F gives len=0x20. first==last gives len=1.
- States:
  - IDLE: cpu_rst=1.
    - If full=1 and sched_en=1: latch first_addr into cpu_base_addr and len into cpu_pkt_len, then go to DECIDE.
    - If full=1 and sched_en=0: stay in IDLE.
  - DECIDE (1 cycle):
    - If bypass=1 or len > MAX_PKT_WORDS, go to RELEASE and flag the packet as bypass.
    - Else go to LOAD.
  - LOAD (1 cycle): cpu_mem_sel=1, cpu_rst=0, timer cleared. Next cycle enters RUN with cpu_start=1 for exactly that first RUN cycle.
  - RUN: cpu_mem_sel=1, cpu_rst=0, timer increments every cycle.
    - cpu_done=1 goes to RELEASE.
    - Else timer==TIMEOUT_CYC-1 goes to RELEASE with the timeout flag set.
    - cpu_done and timeout in the same cycle: done wins and the timeout is not counted.
    - cpu_done is ignored in every state except RUN.
  - RELEASE (1 cycle):
    - data_processed=1, cpu_mem_sel=0, cpu_rst=1.
    - pkt_cnt+1. bypass_cnt+1 if bypass flag. timeout_cnt+1 if timeout flag.
    - Go to DRAIN.
  - DRAIN: wait for full=0, then go to IDLE. A full deasserting and reasserting in consecutive cycles is a new packet, taken from IDLE.
- Unexpected full drop: full=0 in DECIDE/LOAD/RUN sets err=1, drops cpu_mem_sel and returns to IDLE without pulsing data_processed. pkt_cnt is unchanged. err clears only on rst.
- Counters saturate at all-ones.
- Changes to bypass/sched_en are sampled only in DECIDE/IDLE respectively.
- Minimum full-to-data_processed latency:
  - bypass path: 3 cycles (IDLE, DECIDE, RELEASE).
  - CPU path with immediate done: 5 cycles.
- busy is combinational from the state register.

Test Plan:
- Reset, sched_en=1, full=1, first=0x10, last=0x2F, cpu_done 10 cycles after cpu_start:
  - cpu_pkt_len=0x20, cpu_base_addr=0x10.
  - cpu_start is a single pulse, cpu_mem_sel high LOAD..RUN.
  - data_processed is one pulse the cycle after done.
  - pkt_cnt=1.
- Wrap: first=0xF0, last=0x0F: cpu_pkt_len=0x020. With MAX_PKT_WORDS=16: bypass path, no cpu_start, data_processed 3 cycles after full, bypass_cnt=1.
- cpu_done never asserted, TIMEOUT_CYC=8: data_processed exactly after 8 RUN cycles, timeout_cnt=1, cpu_rst returns to 1.
- cpu_done asserted on the timeout cycle: timeout_cnt stays 0, pkt_cnt=1.
- full dropped during RUN: err=1, state IDLE, no data_processed, pkt_cnt unchanged. Next full with sched_en=0: stays IDLE, busy=0.
- rst pulsed mid-RUN: next cycle cpu_mem_sel=0, cpu_rst=1, counters 0. A following packet processes normally.
